// File: rtl/instr_prefetch.sv
// Instruction prefetch buffer: single-outstanding fetches from instruction memory
// into a DEPTH-entry {pc, word} FIFO, with flush and re-steer on redirect.
module instr_prefetch #(
  parameter int DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   nReset,
  output logic                   MemReq,
  output logic [15:0]            MemAddr,
  input  logic                   MemValid,
  input  logic [31:0]            MemRData,
  output logic [31:0]            Instr,
  output logic [15:0]            InstrPC,
  output logic                   InstrValid,
  input  logic                   InstrReady,
  input  logic                   Redirect,
  input  logic [15:0]            RedirectAddr,
  output logic [$clog2(DEPTH):0] Level
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        r_state;
  logic [15:0]   r_fetch_addr;
  logic [15:0]   r_fifo_pc   [DEPTH];
  logic [31:0]   r_fifo_data [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          r_req;
  logic [15:0]   r_req_addr;

  logic          w_pop;
  logic          w_push;
  logic [15:0]   w_next_addr;
  logic [PW:0]   w_post_count;

  assign w_pop        = (r_count != '0) && InstrReady && !Redirect;
  assign w_push       = (r_state == WAIT) && MemValid && !Redirect;
  assign w_next_addr  = r_fetch_addr + 16'd4;
  assign w_post_count = r_count + (PW+1)'(1) - (PW+1)'(w_pop);

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      r_state      <= IDLE;
      r_fetch_addr <= '0;
      r_rd_ptr     <= '0;
      r_wr_ptr     <= '0;
      r_count      <= '0;
      r_req        <= 1'b0;
      r_req_addr   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_pc[i]   <= '0;
        r_fifo_data[i] <= '0;
      end
    end else begin
      r_req <= 1'b0;
      if (Redirect) begin
        r_count      <= '0;
        r_rd_ptr     <= '0;
        r_wr_ptr     <= '0;
        r_fetch_addr <= RedirectAddr & 16'hFFFC;
        // A response landing with the redirect closes the outstanding request.
        if (r_state == IDLE || MemValid) r_state <= IDLE;
        else                             r_state <= DROP;
      end else begin
        if (w_push) begin
          r_fifo_pc[r_wr_ptr]   <= r_fetch_addr;
          r_fifo_data[r_wr_ptr] <= MemRData;
          r_wr_ptr              <= r_wr_ptr + PW'(1);
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
        r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);

        case (r_state)
          IDLE: begin
            if (r_count < FULL) begin
              r_req      <= 1'b1;
              r_req_addr <= r_fetch_addr;
              r_state    <= WAIT;
            end
          end
          WAIT: begin
            if (MemValid) begin
              r_fetch_addr <= w_next_addr;
              // Chain the next fetch on the response edge while room remains.
              if (w_post_count < FULL) begin
                r_req      <= 1'b1;
                r_req_addr <= w_next_addr;
              end else begin
                r_state <= IDLE;
              end
            end
          end
          DROP: begin
            if (MemValid) r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign MemReq     = r_req;
  assign MemAddr    = r_req_addr;
  assign Instr      = r_fifo_data[r_rd_ptr];
  assign InstrPC    = r_fifo_pc[r_rd_ptr];
  assign InstrValid = (r_count != '0);
  assign Level      = r_count;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: queue-based reference of the delivered instruction
// stream plus a latency-programmable memory model, directed and random phases.
module tb_instr_prefetch;
  localparam int DEPTH = 4;

  logic        Clock = 1'b0;
  logic        nReset = 1'b1;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemValid = 1'b0;
  logic [31:0] MemRData = '0;
  logic [31:0] Instr;
  logic [15:0] InstrPC;
  logic        InstrValid;
  logic        InstrReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectAddr = '0;
  logic [2:0]  Level;

  instr_prefetch #(.DEPTH(DEPTH)) dut (
    .Clock(Clock), .nReset(nReset),
    .MemReq(MemReq), .MemAddr(MemAddr), .MemValid(MemValid), .MemRData(MemRData),
    .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid), .InstrReady(InstrReady),
    .Redirect(Redirect), .RedirectAddr(RedirectAddr), .Level(Level)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [15:0] a);
    return {~a, a} ^ 32'h5A3C_96E1;
  endfunction

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] data;
  } ent_t;

  // Reference: expected FIFO contents, next fetch address, outstanding request.
  ent_t        q[$];
  logic [15:0] exp_addr = '0;
  bit          mdl_out = 0;
  bit          out_live = 0;
  // Memory model
  bit          mem_pend = 0;
  int          mem_cnt = 0;
  logic [15:0] mem_a = '0;
  int          lat_cfg = 1;
  // Observations
  int          stall = 0;
  logic [15:0] deliv[$];
  int          req_cnt = 0;
  logic [15:0] last_req = '0;

  task automatic step(input bit rdy, input bit redir, input logic [15:0] raddr, input bit spur);
    bit          vld;
    bit          pop;
    bit          out_before;
    logic [15:0] ra;
    ent_t        e;
    @(negedge Clock);
    chk_eq("level", 32'(Level), 32'(q.size()));
    chk_eq("instr_valid", 32'(InstrValid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk_eq("instr_pc", 32'(InstrPC), 32'(q[0].pc));
      chk_eq("instr", Instr, q[0].data);
    end
    out_before = mdl_out;
    vld = 0;
    ra  = mem_a;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        vld = 1;
        mem_pend = 0;
      end
    end
    if (MemReq) begin
      chk_eq("req_addr", 32'(MemAddr), 32'(exp_addr));
      chk_eq("req_single", 32'(mdl_out), 0);
      chk_eq("req_room", 32'(q.size() < DEPTH), 1);
      mdl_out  = 1;
      out_live = 1;
      exp_addr = exp_addr + 16'd4;
      mem_pend = 1;
      mem_a    = MemAddr;
      mem_cnt  = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 4));
      req_cnt++;
      last_req = MemAddr;
    end
    if (redir) stall = 0;
    else if (!out_before && q.size() < DEPTH && !MemReq) stall++;
    else stall = 0;
    chk_eq("fetch_stall", 32'(stall >= 2), 0);

    MemValid     = vld | spur;
    MemRData     = vld ? mem_word(ra) : $urandom();
    InstrReady   = rdy;
    Redirect     = redir;
    RedirectAddr = raddr;

    pop = (q.size() != 0) && rdy && !redir;
    if (pop) begin
      deliv.push_back(q[0].pc);
      void'(q.pop_front());
    end
    if (redir) begin
      q.delete();
      exp_addr = raddr & 16'hFFFC;
      out_live = 0;
    end else if (vld && out_live) begin
      e.pc   = ra;
      e.data = mem_word(ra);
      q.push_back(e);
    end
    if (vld) begin
      mdl_out  = 0;
      out_live = 0;
    end
  endtask

  task automatic do_reset(input bit spurious);
    #2 nReset = 1'b0;
    #1;
    chk_eq("rst_memreq", 32'(MemReq), 0);
    chk_eq("rst_memaddr", 32'(MemAddr), 0);
    chk_eq("rst_valid", 32'(InstrValid), 0);
    chk_eq("rst_instr", Instr, 0);
    chk_eq("rst_pc", 32'(InstrPC), 0);
    chk_eq("rst_level", 32'(Level), 0);
    MemValid = 1'b0;
    Redirect = 1'b0;
    InstrReady = 1'b0;
    q.delete();
    exp_addr = '0;
    mdl_out = 0;
    out_live = 0;
    mem_pend = 0;
    stall = 0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    MemValid = spurious;
    MemRData = $urandom();
    nReset = 1'b1;
    @(posedge Clock);
    #1;
    chk_eq("first_req", 32'(MemReq), 1);
    chk_eq("first_req_addr", 32'(MemAddr), 0);
    MemValid = 1'b0;
  endtask

  initial begin
    int  i_req;
    int  i_vld;
    int  maxl;
    bit  found;

    // Phase 1: 1-cycle memory, always ready
    lat_cfg = 1;
    do_reset(0);
    deliv.delete();
    i_req = -1;
    i_vld = -1;
    maxl  = 0;
    for (int i = 0; i < 30; i++) begin
      step(1, 0, 16'h0, 0);
      if (MemReq && i_req < 0) i_req = i;
      if (InstrValid && i_vld < 0) i_vld = i;
      if (int'(Level) > maxl) maxl = int'(Level);
    end
    chk_eq("t1_valid_latency", 32'(i_vld - i_req), 2);
    chk_eq("t1_max_level", 32'(maxl), 1);
    chk_eq("t1_pc0", 32'(deliv[0]), 32'h0000);
    chk_eq("t1_pc1", 32'(deliv[1]), 32'h0004);
    chk_eq("t1_pc2", 32'(deliv[2]), 32'h0008);

    // Phase 2: stalled consumer fills the FIFO
    step(0, 1, 16'h0000, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 16'h0, 0);
    req_cnt = 0;
    for (int i = 0; i < 10; i++) step(0, 0, 16'h0, 0);
    chk_eq("t2_full_level", 32'(Level), 4);
    chk_eq("t2_no_req_full", 32'(req_cnt), 0);
    step(1, 0, 16'h0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 16'h0, 0);
    chk_eq("t2_one_req", 32'(req_cnt), 1);
    chk_eq("t2_req_addr", 32'(last_req), 32'h0010);
    chk_eq("t2_refull", 32'(Level), 4);

    // Phase 3: 3-cycle memory, redirect while a request is in flight
    lat_cfg = 3;
    step(1, 1, 16'h0000, 0);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1, 0, 16'h0, 0);
      if (MemReq && MemAddr == 16'h0008) found = 1;
    end
    chk_eq("t3_saw_req8", 32'(found), 1);
    req_cnt = 0;
    step(1, 1, 16'h0102, 0);
    deliv.delete();
    step(1, 0, 16'h0, 0);
    chk_eq("t3_valid_low", 32'(InstrValid), 0);
    for (int i = 0; i < 30 && req_cnt == 0; i++) step(1, 0, 16'h0, 0);
    chk_eq("t3_new_req", 32'(last_req), 32'h0100);
    for (int i = 0; i < 30 && deliv.size() == 0; i++) step(1, 0, 16'h0, 0);
    chk_eq("t3_first_pc", 32'(deliv.size() > 0 ? deliv[0] : 16'hDEAD), 32'h0100);

    // Phase 4: redirect coinciding with a response and a pop
    lat_cfg = 1;
    step(0, 1, 16'h0000, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_pend && mem_cnt == 1 && q.size() == 3) found = 1;
      else step(0, 0, 16'h0, 0);
    end
    chk_eq("t4_setup", 32'(found), 1);
    req_cnt = 0;
    step(1, 1, 16'h0200, 0);
    deliv.delete();
    step(1, 0, 16'h0, 0);
    chk_eq("t4_level0", 32'(Level), 0);
    for (int i = 0; i < 20 && req_cnt == 0; i++) step(1, 0, 16'h0, 0);
    chk_eq("t4_new_req", 32'(last_req), 32'h0200);
    for (int i = 0; i < 20 && deliv.size() == 0; i++) step(1, 0, 16'h0, 0);
    chk_eq("t4_first_pc", 32'(deliv.size() > 0 ? deliv[0] : 16'hDEAD), 32'h0200);

    // Phase 5: address wrap
    lat_cfg = 0;
    step(1, 1, 16'hFFF8, 0);
    deliv.delete();
    for (int i = 0; i < 100 && deliv.size() < 4; i++) step(1, 0, 16'h0, 0);
    chk_eq("t5_count", 32'(deliv.size() >= 4), 1);
    if (deliv.size() >= 4) begin
      chk_eq("t5_pc0", 32'(deliv[0]), 32'hFFF8);
      chk_eq("t5_pc1", 32'(deliv[1]), 32'hFFFC);
      chk_eq("t5_pc2", 32'(deliv[2]), 32'h0000);
      chk_eq("t5_pc3", 32'(deliv[3]), 32'h0004);
    end

    // Phase 6: reset in WAIT with two entries held
    lat_cfg = 2;
    step(0, 1, 16'h0040, 0);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(0, 0, 16'h0, 0);
      if (Level == 3'd2 && mem_pend) found = 1;
    end
    chk_eq("t6_setup", 32'(found), 1);
    do_reset(1);
    deliv.delete();
    for (int i = 0; i < 20; i++) step(1, 0, 16'h0, 0);
    chk_eq("t6_restart_pc", 32'(deliv.size() > 0 ? deliv[0] : 16'hDEAD), 32'h0000);

    // Phase 7: random traffic
    lat_cfg = 0;
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 4, 16'($urandom()), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
